// File: rtl/object_position_filter_pkg.sv
// Shared definitions for the object position filter and the motor controller
// that consumes its output.
package object_position_filter_pkg;

    localparam int POS_W = 8;
    localparam logic [POS_W-1:0] CENTER_POS = 8'd128;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2
    } track_state_t;

    function automatic logic [POS_W-1:0] abs_diff(input logic [POS_W-1:0] a,
                                                  input logic [POS_W-1:0] b);
        logic [POS_W-1:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
        return d;
    endfunction

endpackage

// File: rtl/object_position_filter_pos_window.sv
// Four-entry sample window with saturating fill count and a truncated average.
module pos_window4
    import object_position_filter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             restart,
    input  logic             shift,
    input  logic [POS_W-1:0] din,
    output logic [1:0]       fill,
    output logic [POS_W-1:0] avg
);

    logic [3:0][POS_W-1:0] win_r;
    logic [1:0]            fill_r;
    logic [9:0]            sum_s;

    // Window storage: newest sample is entry 0; restart keeps only the new sample.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            win_r  <= {4{8'd0}};
            fill_r <= 2'd0;
        end else if (restart) begin
            win_r  <= {8'd0, 8'd0, 8'd0, din};
            fill_r <= 2'd1;
        end else if (shift) begin
            win_r  <= {win_r[2], win_r[1], win_r[0], din};
            fill_r <= (fill_r == 2'd3) ? 2'd3 : fill_r + 2'd1;
        end else begin
            win_r  <= win_r;
            fill_r <= fill_r;
        end
    end

    // Ten bits hold 4 x 255 = 1020 without overflow.
    always_comb begin
        sum_s = {2'b00, win_r[0]} + {2'b00, win_r[1]}
              + {2'b00, win_r[2]} + {2'b00, win_r[3]};
    end

    assign avg  = sum_s[9:2];
    assign fill = fill_r;

endmodule

// File: rtl/object_position_filter.sv
// Filters CNN detections into a stable horizontal object position with
// acquisition, outlier rejection and track timeout.
module object_position_filter
    import object_position_filter_pkg::*;
#(
    parameter logic [7:0]  CONF_THRESH    = 8'd64,
    parameter logic [7:0]  MAX_JUMP       = 8'd64,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       det_valid,
    output logic       det_ready,
    input  logic [7:0] det_x,
    input  logic [7:0] det_conf,
    output logic [7:0] object_position,
    output logic [1:0] track_state,
    output logic       lost
);

    logic         ready_r;
    logic         smp_valid_r;
    logic [7:0]   smp_x_r;
    track_state_t state_r, next_state_s;
    logic [1:0]   rej_r, rej_next_s;
    logic [23:0]  to_r, to_next_s;
    logic [7:0]   pos_r;
    logic         lost_r, lost_next_s;
    logic         clear_s, restart_s, shift_s;
    logic [1:0]   fill_s;
    logic [7:0]   avg_s;
    logic         outlier_s, timeout_hit_s;

    // Accept stage: low-confidence detections never reach the filter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r     <= 1'b0;
            smp_valid_r <= 1'b0;
            smp_x_r     <= 8'd0;
        end else begin
            ready_r     <= 1'b1;
            smp_valid_r <= det_valid && ready_r && (det_conf >= CONF_THRESH);
            smp_x_r     <= det_x;
        end
    end

    pos_window4 u_window (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear_s),
        .restart (restart_s),
        .shift   (shift_s),
        .din     (smp_x_r),
        .fill    (fill_s),
        .avg     (avg_s)
    );

    assign outlier_s     = abs_diff(smp_x_r, avg_s) > MAX_JUMP;
    assign timeout_hit_s = (to_r == TIMEOUT_CYCLES - 24'd1);

    // Next-state logic; a qualified sample always takes precedence over timeout.
    always_comb begin
        next_state_s = state_r;
        rej_next_s   = rej_r;
        to_next_s    = to_r;
        lost_next_s  = 1'b0;
        clear_s      = 1'b0;
        restart_s    = 1'b0;
        shift_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                to_next_s  = 24'd0;
                rej_next_s = 2'd0;
                if (smp_valid_r) begin
                    shift_s      = 1'b1;
                    next_state_s = ST_ACQUIRE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACQUIRE: begin
                if (smp_valid_r) begin
                    shift_s   = 1'b1;
                    to_next_s = 24'd0;
                    if (fill_s == 2'd3) begin
                        next_state_s = ST_TRACK;
                    end else begin
                        next_state_s = ST_ACQUIRE;
                    end
                end else if (timeout_hit_s) begin
                    clear_s      = 1'b1;
                    to_next_s    = 24'd0;
                    lost_next_s  = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    to_next_s = to_r + 24'd1;
                end
            end
            ST_TRACK: begin
                if (smp_valid_r) begin
                    to_next_s = 24'd0;
                    if (!outlier_s) begin
                        shift_s    = 1'b1;
                        rej_next_s = 2'd0;
                    end else if (rej_r == 2'd2) begin
                        // Persistent disagreement: the object really moved, re-acquire there.
                        restart_s    = 1'b1;
                        rej_next_s   = 2'd0;
                        next_state_s = ST_ACQUIRE;
                    end else begin
                        rej_next_s = rej_r + 2'd1;
                    end
                end else if (timeout_hit_s) begin
                    clear_s      = 1'b1;
                    to_next_s    = 24'd0;
                    rej_next_s   = 2'd0;
                    lost_next_s  = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    to_next_s = to_r + 24'd1;
                end
            end
            default: begin
                clear_s      = 1'b1;
                to_next_s    = 24'd0;
                rej_next_s   = 2'd0;
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            rej_r   <= 2'd0;
            to_r    <= 24'd0;
            pos_r   <= CENTER_POS;
            lost_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            rej_r   <= rej_next_s;
            to_r    <= to_next_s;
            pos_r   <= (state_r == ST_TRACK) ? avg_s : CENTER_POS;
            lost_r  <= lost_next_s;
        end
    end

    assign det_ready       = ready_r;
    assign object_position = pos_r;
    assign track_state     = state_r;
    assign lost            = lost_r;

endmodule

// File: tb/tb_object_position_filter.sv
// Directed vector bench for object_position_filter with a short timeout.
module tb_object_position_filter;

    logic       clk = 1'b0;
    logic       rst;
    logic       det_valid;
    logic       det_ready;
    logic [7:0] det_x;
    logic [7:0] det_conf;
    logic [7:0] object_position;
    logic [1:0] track_state;
    logic       lost;

    object_position_filter #(
        .CONF_THRESH    (8'd64),
        .MAX_JUMP       (8'd64),
        .TIMEOUT_CYCLES (24'd16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .det_valid       (det_valid),
        .det_ready       (det_ready),
        .det_x           (det_x),
        .det_conf        (det_conf),
        .object_position (object_position),
        .track_state     (track_state),
        .lost            (lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_i;
        logic       valid_i;
        logic [7:0] x_i;
        logic [7:0] conf_i;
        logic [1:0] st_e;
        logic [7:0] pos_e;
        logic       lost_e;
        logic       rdy_e;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic v, input logic [7:0] x, input logic [7:0] c,
                       input logic [1:0] st, input logic [7:0] p, input logic l, input logic rd);
        vec_t t;
        t.rst_i = r; t.valid_i = v; t.x_i = x; t.conf_i = c;
        t.st_e = st; t.pos_e = p; t.lost_e = l; t.rdy_e = rd;
        vecs.push_back(t);
    endtask

    task automatic idle(input int n, input logic [1:0] st, input logic [7:0] p);
        for (int i = 0; i < n; i++) add(1'b0, 1'b0, 8'd0, 8'd0, st, p, 1'b0, 1'b1);
    endtask

    task automatic drive(input logic r, input logic v, input logic [7:0] x, input logic [7:0] c);
        @(negedge clk);
        rst = r; det_valid = v; det_x = x; det_conf = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int j;
        rst = 1'b1; det_valid = 1'b0; det_x = 8'd0; det_conf = 8'd0;

        // Reset and acquisition of 40,44,48,52 -> average 46.
        add(1, 0, 8'd0,   8'd0,   2'd0, 8'd128, 0, 0);
        add(0, 0, 8'd0,   8'd0,   2'd0, 8'd128, 0, 1);
        add(0, 1, 8'd40,  8'd200, 2'd0, 8'd128, 0, 1);
        add(0, 1, 8'd44,  8'd200, 2'd1, 8'd128, 0, 1);
        add(0, 1, 8'd48,  8'd200, 2'd1, 8'd128, 0, 1);
        add(0, 1, 8'd52,  8'd200, 2'd1, 8'd128, 0, 1);
        add(0, 0, 8'd0,   8'd0,   2'd2, 8'd128, 0, 1);
        add(0, 0, 8'd0,   8'd0,   2'd2, 8'd46,  0, 1);
        // Confidence 63 is below threshold.
        add(0, 1, 8'd10,  8'd63,  2'd2, 8'd46,  0, 1);
        add(0, 0, 8'd0,   8'd0,   2'd2, 8'd46,  0, 1);
        // Three outliers at 200 -> re-acquire.
        add(0, 1, 8'd200, 8'd200, 2'd2, 8'd46,  0, 1);
        add(0, 1, 8'd200, 8'd200, 2'd2, 8'd46,  0, 1);
        add(0, 1, 8'd200, 8'd200, 2'd2, 8'd46,  0, 1);
        add(0, 0, 8'd0,   8'd0,   2'd1, 8'd46,  0, 1);
        add(0, 0, 8'd0,   8'd0,   2'd1, 8'd128, 0, 1);
        add(0, 1, 8'd200, 8'd200, 2'd1, 8'd128, 0, 1);
        add(0, 1, 8'd200, 8'd200, 2'd1, 8'd128, 0, 1);
        add(0, 1, 8'd200, 8'd200, 2'd1, 8'd128, 0, 1);
        add(0, 0, 8'd0,   8'd0,   2'd2, 8'd128, 0, 1);
        add(0, 0, 8'd0,   8'd0,   2'd2, 8'd200, 0, 1);
        // Two rejects, an in-range sample at exactly threshold confidence, two rejects: still tracking.
        add(0, 1, 8'd0,   8'd200, 2'd2, 8'd200, 0, 1);
        add(0, 1, 8'd0,   8'd200, 2'd2, 8'd200, 0, 1);
        add(0, 1, 8'd200, 8'd64,  2'd2, 8'd200, 0, 1);
        add(0, 1, 8'd0,   8'd200, 2'd2, 8'd200, 0, 1);
        add(0, 1, 8'd0,   8'd200, 2'd2, 8'd200, 0, 1);
        // Timeout 16 cycles after the last reject is processed.
        idle(16, 2'd2, 8'd200);
        add(0, 0, 8'd0,   8'd0,   2'd0, 8'd200, 1, 1);
        add(0, 0, 8'd0,   8'd0,   2'd0, 8'd128, 0, 1);
        // New track at 100; a sample on the expiry cycle defers the timeout.
        add(0, 1, 8'd100, 8'd200, 2'd0, 8'd128, 0, 1);
        add(0, 1, 8'd100, 8'd200, 2'd1, 8'd128, 0, 1);
        add(0, 1, 8'd100, 8'd200, 2'd1, 8'd128, 0, 1);
        add(0, 1, 8'd100, 8'd200, 2'd1, 8'd128, 0, 1);
        add(0, 0, 8'd0,   8'd0,   2'd2, 8'd128, 0, 1);
        idle(14, 2'd2, 8'd100);
        add(0, 1, 8'd100, 8'd200, 2'd2, 8'd100, 0, 1);
        idle(16, 2'd2, 8'd100);
        add(0, 0, 8'd0,   8'd0,   2'd0, 8'd100, 1, 1);
        add(0, 0, 8'd0,   8'd0,   2'd0, 8'd128, 0, 1);
        // Full-scale window, then reset mid-track.
        add(0, 1, 8'd255, 8'd255, 2'd0, 8'd128, 0, 1);
        add(0, 1, 8'd255, 8'd255, 2'd1, 8'd128, 0, 1);
        add(0, 1, 8'd255, 8'd255, 2'd1, 8'd128, 0, 1);
        add(0, 1, 8'd255, 8'd255, 2'd1, 8'd128, 0, 1);
        add(0, 0, 8'd0,   8'd0,   2'd2, 8'd128, 0, 1);
        add(0, 0, 8'd0,   8'd0,   2'd2, 8'd255, 0, 1);
        add(1, 1, 8'd255, 8'd255, 2'd0, 8'd128, 0, 0);
        add(0, 0, 8'd0,   8'd0,   2'd0, 8'd128, 0, 1);
        add(0, 0, 8'd0,   8'd0,   2'd0, 8'd128, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_i, vecs[i].valid_i, vecs[i].x_i, vecs[i].conf_i);
            n_vec++;
            if (track_state !== vecs[i].st_e || object_position !== vecs[i].pos_e ||
                lost !== vecs[i].lost_e || det_ready !== vecs[i].rdy_e) begin
                n_bad++;
                $display("FAIL vec%0d: got state=%0d pos=%0d lost=%0b ready=%0b, want state=%0d pos=%0d lost=%0b ready=%0b",
                         i, track_state, object_position, lost, det_ready,
                         vecs[i].st_e, vecs[i].pos_e, vecs[i].lost_e, vecs[i].rdy_e);
            end
        end

        // Bounded wait for the lost pulse after a fresh track at 128.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'd128, 8'd200);
        j = -1;
        for (int k = 0; k < 40; k++) begin
            drive(1'b0, 1'b0, 8'd0, 8'd0);
            if (lost === 1'b1) begin
                j = k;
                break;
            end
        end
        n_vec++;
        if (j != 16) begin
            n_bad++;
            $display("FAIL timeout_latency: lost seen at idle cycle %0d, want 16", j);
        end
        drive(1'b0, 1'b0, 8'd0, 8'd0);
        n_vec++;
        if (lost !== 1'b0 || track_state !== 2'd0 || object_position !== 8'd128) begin
            n_bad++;
            $display("FAIL lost_width: got lost=%0b state=%0d pos=%0d, want 0 0 128",
                     lost, track_state, object_position);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/object_position_filter.md
OBJECT_POSITION_FILTER -- requirements
Module: object_position_filter

Interface
REQ-001 Parameter CONF_THRESH, default 8'd64: minimum detection confidence accepted; det_conf >= CONF_THRESH qualifies.
REQ-002 Parameter MAX_JUMP, default 8'd64: largest allowed |det_x - current average| while tracking.
REQ-003 Parameter TIMEOUT_CYCLES, default 24'd1_000_000: cycles without a qualified sample before track is dropped.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 det_valid  input  1  CNN detection present this cycle.
REQ-007 det_ready  output  1  block can take a detection this cycle.
REQ-008 det_x  input  8  detected object horizontal centre; 0 is left, 255 is right.
REQ-009 det_conf  input  8  detection confidence.
REQ-010 object_position  output  8  filtered position for the motor controller; 128 is centre.
REQ-011 track_state  output  2  0 IDLE, 1 ACQUIRE, 2 TRACK.
REQ-012 lost  output  1  one-cycle pulse when a track is dropped by timeout.

Function
REQ-013 det_ready SHALL be 1 in every cycle except while rst is high; a detection is accepted when det_valid && det_ready.
REQ-014 An accepted detection with det_conf < CONF_THRESH SHALL be discarded with no effect on window, state or timeout counter.
REQ-015 Window: 4 x 8-bit sample registers plus a 2-bit fill count; a qualified sample shifts in and the oldest shifts out.
REQ-016 Sum: 10-bit, no overflow; average = sum >> 2 (truncate).
REQ-017 IDLE: window empty; object_position = 128; a qualified sample enters the window and the state moves to ACQUIRE.
REQ-018 ACQUIRE: 1-3 samples held; object_position stays 128; the 4th qualified sample moves the state to TRACK.
REQ-019 TRACK: object_position = average of the 4 window entries.
REQ-020 TRACK outlier rule: a qualified sample with |det_x - average| > MAX_JUMP is rejected and the 2-bit reject counter increments; an in-range sample clears the counter.
REQ-021 A 3rd consecutive rejection SHALL clear the window, load that sample as entry 0, clear the counter and enter ACQUIRE; object_position returns to 128.
REQ-022 Timeout counter: 24-bit; cleared on every sample that enters the window or is rejected as an outlier; otherwise increments in ACQUIRE/TRACK and holds 0 in IDLE.
REQ-023 When the counter reaches TIMEOUT_CYCLES-1 with no qualified sample that cycle, the window SHALL clear and the state SHALL go to IDLE, with lost = 1 for exactly that next cycle.
REQ-024 If a qualified sample arrives in the same cycle as a timeout, the sample SHALL win: no timeout and no lost pulse.
REQ-025 Latency: sample accepted at edge N -> window/state update at N+1 -> object_position registered at N+2.
REQ-026 All outputs SHALL be registered; object_position SHALL never be driven from combinational logic.

Reset
REQ-027 With rst high at a clock edge: track_state = IDLE, object_position = 128, lost = 0, det_ready = 0, window/fill/reject/timeout counters = 0.
REQ-028 rst asserted mid-track SHALL abandon the track with no lost pulse; the first cycle after rst deasserts has det_ready = 1.

Structure
REQ-029 Shared package: state encoding (IDLE/ACQUIRE/TRACK), CENTER_POS = 8'd128 and the position width, reused by motor_control.
REQ-030 One sub-module, pos_window4: shift window, fill count, 10-bit sum and average; the FSM, outlier check and timeout stay in the top.

Verification (bench uses TIMEOUT_CYCLES = 16)
REQ-031 After reset, 4 samples x = 40, 44, 48, 52 with conf 200 -> state goes IDLE->ACQUIRE->TRACK; object_position = 46 two cycles after the 4th accept.
REQ-032 Sample x = 10 with conf 63 in TRACK -> discarded; object_position and timeout counter behave as if no sample arrived.
REQ-033 TRACK at average 46, then x = 200 three times -> first two rejected with output held at 46; after the third, state = ACQUIRE and object_position = 128.
REQ-034 TRACK, then no qualified sample for 16 cycles -> state = IDLE, object_position = 128, lost high for exactly 1 cycle; a sample on the expiry cycle prevents the timeout.
REQ-035 rst pulsed for one cycle during TRACK -> all outputs take their reset values, no lost pulse, det_ready = 1 the following cycle.
REQ-036 Window of 255 x 4 -> sum 1020 with no overflow; object_position = 255.
